// File: rtl/in_mapper_arbiter.sv
// in_mapper_arbiter: merges three AER sources into the single in-mapper input.
// - Round-robin grant across the three sources.
// - One registered output stage that can accept a new event in the same cycle
//   it delivers the previous one.
// - Run/dump command pulses taken from the edges of the spnn_run level.
// - Saturating per-source counts of forwarded events.
//
// Handshake rule (sources and output alike): a word moves on a rising clk
// edge only when its valid and ready are both 1. A source holds its word and
// valid stable until that happens. A source's ready may depend on its own
// valid, because the grant is only given to a requesting source.
module in_mapper_arbiter #(
  parameter int AER_WIDTH = 32,
  parameter int TAG_EN    = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           src_en,
  input  logic                 spnn_run,
  input  logic                 cnt_clr,
  input  logic [AER_WIDTH-1:0] s0_data,
  input  logic [AER_WIDTH-1:0] s1_data,
  input  logic [AER_WIDTH-1:0] s2_data,
  input  logic                 s0_vld,
  input  logic                 s1_vld,
  input  logic                 s2_vld,
  output logic                 s0_rdy,
  output logic                 s1_rdy,
  output logic                 s2_rdy,
  output logic [AER_WIDTH-1:0] oaer_data,
  output logic                 oaer_vld,
  input  logic                 oaer_rdy,
  output logic                 dump_on,
  output logic                 dump_off,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1,
  output logic [CNT_WIDTH-1:0] cnt2
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Output stage registers
  logic [AER_WIDTH-1:0] oaer_data_q, oaer_data_d;
  logic                 oaer_vld_q,  oaer_vld_d;

  // Round-robin pointer: index searched first. Only values 0..2 are used.
  logic [1:0] ptr_q, ptr_d;

  // Command sequencer registers
  logic run_q,      run_d;
  logic dump_on_q,  dump_on_d;
  logic dump_off_q, dump_off_d;

  // Per-source event counters
  logic [2:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Arbitration signals
  logic [2:0]           req;
  logic [2:0]           grant;
  logic                 load;
  logic                 xfer;
  logic [1:0]           gnt_idx;
  logic [AER_WIDTH-1:0] sel_word;
  logic [AER_WIDTH-1:0] out_word;

  assign req  = {s2_vld & src_en[2], s1_vld & src_en[1], s0_vld & src_en[0]};

  // The stage can take a word when it is empty or being drained this cycle.
  assign load = ~oaer_vld_q | oaer_rdy;

  // Round-robin grant: search pointer, pointer+1, pointer+2 (mod 3).
  always_comb begin
    grant = 3'b000;
    case (ptr_q)
      2'd1: begin
        if      (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      2'd2: begin
        if      (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if      (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
    if (!load) grant = 3'b000;
  end

  // Ready goes only to the granted source. It is held low while in reset, so a
  // source is never told it was accepted by a register that cannot capture.
  assign s0_rdy = grant[0] & ~rst;
  assign s1_rdy = grant[1] & ~rst;
  assign s2_rdy = grant[2] & ~rst;

  // A grant always lands on a requesting source, so any grant is a transfer.
  assign xfer = |grant;

  // Encode the granted index and select its word.
  always_comb begin
    gnt_idx  = 2'd0;
    sel_word = s0_data;
    if (grant[1]) begin
      gnt_idx  = 2'd1;
      sel_word = s1_data;
    end else if (grant[2]) begin
      gnt_idx  = 2'd2;
      sel_word = s2_data;
    end
  end

  // Optional source tag in the two MSBs of the forwarded word.
  always_comb begin
    out_word = sel_word;
    if (TAG_EN != 0) begin
      out_word[AER_WIDTH-1 -: 2] = gnt_idx;
    end
  end

  // Output stage and pointer next state. A held word stays put under back
  // pressure. An empty cycle only clears valid and leaves the pointer alone.
  always_comb begin
    oaer_vld_d  = oaer_vld_q;
    oaer_data_d = oaer_data_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (xfer) begin
        oaer_vld_d  = 1'b1;
        oaer_data_d = out_word;
        ptr_d       = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
      end else begin
        oaer_vld_d  = 1'b0;
      end
    end
  end

  // Saturating counters. A clear wins over an increment in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    for (int n = 0; n < 3; n++) begin
      if (cnt_clr) begin
        cnt_d[n] = '0;
      end else if (grant[n] && (cnt_q[n] != CNT_MAX)) begin
        cnt_d[n] = cnt_q[n] + CNT_ONE;
      end
    end
  end

  // Edge detect on spnn_run. The pulses are registered and one cycle wide.
  // They are mutually exclusive because one edge condition needs spnn_run
  // high and the other needs it low.
  always_comb begin
    run_d      = spnn_run;
    dump_off_d = spnn_run & ~run_q;
    dump_on_d  = ~spnn_run & run_q;
  end

  // State registers. Reset discards any pending output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oaer_data_q <= '0;
      oaer_vld_q  <= 1'b0;
      ptr_q       <= 2'd0;
      run_q       <= 1'b0;
      dump_on_q   <= 1'b0;
      dump_off_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      oaer_data_q <= oaer_data_d;
      oaer_vld_q  <= oaer_vld_d;
      ptr_q       <= ptr_d;
      run_q       <= run_d;
      dump_on_q   <= dump_on_d;
      dump_off_q  <= dump_off_d;
      cnt_q       <= cnt_d;
    end
  end

  assign oaer_data = oaer_data_q;
  assign oaer_vld  = oaer_vld_q;
  assign dump_on   = dump_on_q;
  assign dump_off  = dump_off_q;
  assign cnt0      = cnt_q[0];
  assign cnt1      = cnt_q[1];
  assign cnt2      = cnt_q[2];

endmodule
